// File: rtl/lct_quality_pipe.sv
// Per-channel LCT quality encoder with best-channel select and a per-code quality histogram.
// Latency: q_out 2 cycles after lct_vld_in, best_q/best_idx 3 cycles, cnt_rd 1 cycle after cnt_sel.
// No backpressure: accepts one valid input every cycle; outputs are single-cycle pulses.
module lct_quality_pipe #(
  parameter int NCH   = 2,
  parameter int MXLY  = 3,
  parameter int MXCNT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lct_vld_in,
  input  logic                  mode_sel,
  input  logic [MXLY-1:0]       thresh_a,
  input  logic [MXLY-1:0]       thresh_c,
  input  logic [NCH-1:0]        alct_vld,
  input  logic [NCH-1:0]        clct_vld,
  input  logic [NCH-1:0]        alct_acc,
  input  logic [NCH*MXLY-1:0]   alct_nly,
  input  logic [NCH*MXLY-1:0]   clct_nly,
  input  logic [NCH*4-1:0]      clct_pid,
  input  logic                  cnt_clr,
  input  logic [3:0]            cnt_sel,
  output logic                  q_vld,
  output logic [NCH*4-1:0]      q_out,
  output logic                  best_vld,
  output logic [3:0]            best_q,
  output logic [1:0]            best_idx,
  output logic [MXCNT-1:0]      cnt_rd
);

  // Reset: asserts immediately, releases two clock edges after reset_n rises
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  // Two-flop synchroniser for reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Stage 1: captured channel flags; thresholds and mode are folded in at capture time
  logic                 r_s1_vld;
  logic                 r_s1_mode;
  logic [NCH-1:0]       r_s1_a, r_s1_c, r_s1_acc, r_s1_a4, r_s1_c4, r_s1_cpat, r_s1_xpat;
  logic [NCH-1:0][3:0]  r_s1_pid;
  logic [NCH-1:0]       w_a4, w_c4, w_cpat, w_xpat;

  // Threshold and pattern-class decode of the live inputs
  always_comb begin
    w_a4   = '0;
    w_c4   = '0;
    w_cpat = '0;
    w_xpat = '0;
    for (int i = 0; i < NCH; i++) begin
      w_a4[i]   = alct_nly[i*MXLY +: MXLY] >= thresh_a;
      w_c4[i]   = clct_nly[i*MXLY +: MXLY] >= thresh_c;
      w_cpat[i] = (clct_pid[i*4 +: 4] >= 4'd2) && (clct_pid[i*4 +: 4] <= 4'd10);
      w_xpat[i] = clct_pid[i*4 +: 4] >= 4'd11;
    end
  end

  // Stage 1 register: only a valid input updates the captured state
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_mode <= 1'b0;
      r_s1_a    <= '0;
      r_s1_c    <= '0;
      r_s1_acc  <= '0;
      r_s1_a4   <= '0;
      r_s1_c4   <= '0;
      r_s1_cpat <= '0;
      r_s1_xpat <= '0;
      r_s1_pid  <= '0;
    end else begin
      r_s1_vld <= lct_vld_in;
      if (lct_vld_in) begin
        r_s1_mode <= mode_sel;
        r_s1_a    <= alct_vld;
        r_s1_c    <= clct_vld;
        r_s1_acc  <= alct_acc;
        r_s1_a4   <= w_a4;
        r_s1_c4   <= w_c4;
        r_s1_cpat <= w_cpat;
        r_s1_xpat <= w_xpat;
        r_s1_pid  <= clct_pid;
      end
    end
  end

  // Stage 2: quality table, first matching row wins; code 9 is deliberately unreachable
  logic [NCH-1:0][3:0] w_q;
  logic [NCH-1:0][3:0] r_q;
  logic                r_q_vld;

  // Per-channel quality priority encode
  always_comb begin
    w_q = '0;
    for (int i = 0; i < NCH; i++) begin
      logic v_hq;
      v_hq = r_s1_c4[i] && r_s1_a4[i] && !r_s1_acc[i];
      if      (v_hq && r_s1_pid[i] == 4'd10)                           w_q[i] = 4'd15;
      else if (v_hq && r_s1_pid[i] >= 4'd8 && r_s1_pid[i] <= 4'd9)     w_q[i] = 4'd14;
      else if (v_hq && r_s1_pid[i] >= 4'd6 && r_s1_pid[i] <= 4'd7)     w_q[i] = 4'd13;
      else if (v_hq && r_s1_pid[i] >= 4'd4 && r_s1_pid[i] <= 4'd5)     w_q[i] = 4'd12;
      else if (v_hq && r_s1_pid[i] >= 4'd2 && r_s1_pid[i] <= 4'd3)     w_q[i] = 4'd11;
      else if (r_s1_mode && v_hq && r_s1_xpat[i])                      w_q[i] = 4'd10;
      else if (r_s1_c4[i] && r_s1_a4[i] && r_s1_acc[i] && r_s1_cpat[i]) w_q[i] = 4'd8;
      else if (r_s1_c4[i] && r_s1_a[i] && !r_s1_a4[i] && r_s1_cpat[i])  w_q[i] = 4'd7;
      else if (r_s1_c[i] && !r_s1_c4[i] && r_s1_a4[i] && r_s1_cpat[i])  w_q[i] = 4'd6;
      else if (r_s1_c[i] && !r_s1_c4[i] && r_s1_a[i] && !r_s1_a4[i] && r_s1_cpat[i]) w_q[i] = 4'd5;
      else if (r_s1_mode && r_s1_c[i] && r_s1_a[i] && r_s1_xpat[i])    w_q[i] = 4'd4;
      else if (r_s1_c[i] && r_s1_a[i] && r_s1_pid[i] == 4'd1)          w_q[i] = 4'd3;
      else if (r_s1_c[i] && !r_s1_a[i])                                w_q[i] = 4'd2;
      else if (r_s1_a[i] && !r_s1_c[i])                                w_q[i] = 4'd1;
      else                                                             w_q[i] = 4'd0;
    end
  end

  // Stage 2 register: q_out holds between valid pulses
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_q_vld <= 1'b0;
      r_q     <= '0;
    end else begin
      r_q_vld <= r_s1_vld;
      if (r_s1_vld) r_q <= w_q;
    end
  end

  // Stage 3: best channel, strict compare keeps the lowest index on ties
  logic [3:0] w_best_q, r_best_q;
  logic [1:0] w_best_idx, r_best_idx;
  logic       r_best_vld;

  // Maximum search across channels
  always_comb begin
    w_best_q   = '0;
    w_best_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_q[i] > w_best_q) begin
        w_best_q   = r_q[i];
        w_best_idx = 2'(i);
      end
    end
  end

  // Stage 3 register
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_best_vld <= 1'b0;
      r_best_q   <= '0;
      r_best_idx <= '0;
    end else begin
      r_best_vld <= r_q_vld;
      if (r_q_vld) begin
        r_best_q   <= w_best_q;
        r_best_idx <= w_best_idx;
      end
    end
  end

  // Histogram: one saturating counter per quality code
  logic [15:0][MXCNT-1:0] r_cnt;
  logic [15:0][MXCNT-1:0] w_cnt_nxt;
  logic [MXCNT-1:0]       r_cnt_rd;

  // Next counter values with up to NCH hits per code per cycle
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int k = 0; k < 16; k++) begin
      logic [2:0]       v_hits;
      logic [MXCNT+2:0] v_sum;
      v_hits = '0;
      for (int i = 0; i < NCH; i++) begin
        v_hits = v_hits + 3'(r_q[i] == 4'(k));
      end
      v_sum = {3'b000, r_cnt[k]} + {{MXCNT{1'b0}}, v_hits};
      if (v_sum > {3'b000, {MXCNT{1'b1}}}) w_cnt_nxt[k] = '1;
      else                                 w_cnt_nxt[k] = v_sum[MXCNT-1:0];
    end
  end

  // Counter update (clear wins) and registered read port showing pre-update value
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt    <= '0;
      r_cnt_rd <= '0;
    end else begin
      r_cnt_rd <= r_cnt[cnt_sel];
      if (cnt_clr)      r_cnt <= '0;
      else if (r_q_vld) r_cnt <= w_cnt_nxt;
    end
  end

  assign q_vld    = r_q_vld;
  assign q_out    = r_q;
  assign best_vld = r_best_vld;
  assign best_q   = r_best_q;
  assign best_idx = r_best_idx;
  assign cnt_rd   = r_cnt_rd;

endmodule
